spi_slave: RTL and testbench

SPI responder for the 10-bit command / 8-bit response link driven by `spi_master`. It advertises readiness on `o_spi_slave_sready` and deserialises the 10-bit MOSI frame, MSB first. It hands the frame to the back end with a one-cycle valid pulse. For read frames (header `2'b11`) it fetches an 8-bit reply through a valid/ready handshake and serialises the reply on MISO with a qualifying valid strobe. SCLK is the system clock, so the block samples and drives on `i_spi_slave_clk` rising edges.

---
 rtl/spi_slave.sv | 172 +++++++++++++++++
 tb/tb_spi_slave.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI responder: deserialises a 10-bit MOSI command, hands it to the back end,
// and for read headers (2'b11) fetches and serialises an 8-bit reply on MISO.
module spi_slave #(
    parameter int unsigned TX_TIMEOUT = 16
) (
    input  logic       i_spi_slave_clk,
    input  logic       i_spi_slave_rst_n,
    input  logic       i_spi_slave_ss_bar,
    input  logic       i_spi_slave_mosi,
    output logic       o_spi_slave_miso,
    output logic       o_spi_slave_miso_valid,
    output logic       o_spi_slave_sready,
    output logic [9:0] o_spi_slave_rx_data,
    output logic       o_spi_slave_rx_valid,
    input  logic [7:0] i_spi_slave_tx_data,
    input  logic       i_spi_slave_tx_valid,
    output logic       o_spi_slave_tx_ready,
    output logic       o_spi_slave_err
);

    // state   | meaning
    // IDLE    | ready for a frame, sready follows ss_bar
    // RECV    | shifting in command bits 8..0
    // WAIT_TX | read frame received, waiting for the reply byte
    // SEND    | shifting the reply byte out on MISO
    // DONE    | frame finished, waiting for ss_bar to rise
    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_WAIT_TX, S_SEND, S_DONE
    } state_t;

    localparam logic [7:0] TMR_LOAD = 8'(TX_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [8:0] rx_sh_q, rx_sh_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic       miso_q, miso_d;
    logic       miso_valid_q, miso_valid_d;
    logic       sready_q, sready_d;
    logic [9:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_ready_q, tx_ready_d;
    logic       err_q, err_d;

    always_comb begin
        state_d      = state_q;
        rx_sh_d      = rx_sh_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        tx_sh_d      = tx_sh_q;
        miso_d       = miso_q;
        miso_valid_d = miso_valid_q;
        sready_d     = sready_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        tx_ready_d   = tx_ready_q;
        err_d        = 1'b0;

        // Losing slave select mid-transfer wins over every other event.
        if (i_spi_slave_ss_bar && (state_q inside {S_RECV, S_WAIT_TX, S_SEND})) begin
            state_d      = S_IDLE;
            err_d        = 1'b1;
            miso_d       = 1'b0;
            miso_valid_d = 1'b0;
            tx_ready_d   = 1'b0;
            cnt_d        = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sready_d = i_spi_slave_ss_bar;
                    if (!i_spi_slave_ss_bar) begin
                        rx_sh_d = {8'd0, i_spi_slave_mosi};
                        cnt_d   = 4'd1;
                        state_d = S_RECV;
                    end
                end
                S_RECV: begin
                    if (cnt_q == 4'd9) begin
                        rx_data_d  = {rx_sh_q, i_spi_slave_mosi};
                        rx_valid_d = 1'b1;
                        cnt_d      = 4'd0;
                        if (rx_sh_q[8:7] == 2'b11) begin
                            state_d    = S_WAIT_TX;
                            tx_ready_d = 1'b1;
                            timer_d    = TMR_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        rx_sh_d = {rx_sh_q[7:0], i_spi_slave_mosi};
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
                S_WAIT_TX: begin
                    if (i_spi_slave_tx_valid) begin
                        tx_sh_d      = i_spi_slave_tx_data;
                        miso_d       = i_spi_slave_tx_data[7];
                        miso_valid_d = 1'b1;
                        tx_ready_d   = 1'b0;
                        cnt_d        = 4'd1;
                        state_d      = S_SEND;
                    end else if (timer_q == 8'd0) begin
                        err_d      = 1'b1;
                        tx_ready_d = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
                S_SEND: begin
                    if (cnt_q == 4'd8) begin
                        miso_d       = 1'b0;
                        miso_valid_d = 1'b0;
                        cnt_d        = 4'd0;
                        state_d      = S_DONE;
                    end else begin
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        miso_d  = tx_sh_q[6];
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
                S_DONE: begin
                    if (i_spi_slave_ss_bar) begin
                        state_d  = S_IDLE;
                        sready_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_spi_slave_clk or negedge i_spi_slave_rst_n) begin
        if (!i_spi_slave_rst_n) begin
            state_q      <= S_IDLE;
            rx_sh_q      <= '0;
            cnt_q        <= '0;
            timer_q      <= '0;
            tx_sh_q      <= '0;
            miso_q       <= 1'b0;
            miso_valid_q <= 1'b0;
            sready_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            tx_ready_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_sh_q      <= rx_sh_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            tx_sh_q      <= tx_sh_d;
            miso_q       <= miso_d;
            miso_valid_q <= miso_valid_d;
            sready_q     <= sready_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            tx_ready_q   <= tx_ready_d;
            err_q        <= err_d;
        end
    end

    assign o_spi_slave_miso       = miso_q;
    assign o_spi_slave_miso_valid = miso_valid_q;
    assign o_spi_slave_sready     = sready_q;
    assign o_spi_slave_rx_data    = rx_data_q;
    assign o_spi_slave_rx_valid   = rx_valid_q;
    assign o_spi_slave_tx_ready   = tx_ready_q;
    assign o_spi_slave_err        = err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed frames from the test plan followed by random
// frames, each checked cycle by cycle against timing derived from the frame start.
module tb_spi_slave;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ss_bar;
    logic       mosi;
    logic       miso;
    logic       miso_valid;
    logic       sready;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       err;

    int checks   = 0;
    int failures = 0;
    logic [9:0] last_rx = '0;
    logic [7:0] captured;

    spi_slave #(.TX_TIMEOUT(T)) dut (
        .i_spi_slave_clk        (clk),
        .i_spi_slave_rst_n      (rst_n),
        .i_spi_slave_ss_bar     (ss_bar),
        .i_spi_slave_mosi       (mosi),
        .o_spi_slave_miso       (miso),
        .o_spi_slave_miso_valid (miso_valid),
        .o_spi_slave_sready     (sready),
        .o_spi_slave_rx_data    (rx_data),
        .o_spi_slave_rx_valid   (rx_valid),
        .i_spi_slave_tx_data    (tx_data),
        .i_spi_slave_tx_valid   (tx_valid),
        .o_spi_slave_tx_ready   (tx_ready),
        .o_spi_slave_err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input logic e_sready, input logic e_rxv, input logic [9:0] e_rxd,
                           input logic e_txr, input logic e_err, input logic e_mv,
                           input logic e_miso);
        chk("sready",     16'(sready),     16'(e_sready));
        chk("rx_valid",   16'(rx_valid),   16'(e_rxv));
        chk("rx_data",    16'(rx_data),    16'(e_rxd));
        chk("tx_ready",   16'(tx_ready),   16'(e_txr));
        chk("err",        16'(err),        16'(e_err));
        chk("miso_valid", 16'(miso_valid), 16'(e_mv));
        chk("miso",       16'(miso),       16'(e_miso));
    endtask

    // One frame starting at E0 (k = 0). abort_at: -1 none, -2 random early, else edge index
    // at which ss_bar is first sampled high. tx_valid is offered at edge 10+d if d < T.
    task automatic run_frame(input logic [9:0] frame, input int d, input logic [7:0] reply,
                             input int abort_at, input int tail);
        bit read, timeout;
        int s, tx_end, end_k, r;
        logic e_sready, e_rxv, e_txr, e_err, e_mv, e_miso;
        logic [9:0] e_rxd;
        read    = (frame[9:8] == 2'b11);
        timeout = read && (d >= T);
        s       = 10 + d;
        tx_end  = timeout ? 9 + T : s;
        end_k   = !read ? 10 : (timeout ? 10 + T : s + 9);
        if (abort_at == -2)     r = $urandom_range(1, end_k - 1);
        else if (abort_at >= 1) r = abort_at;
        else                    r = end_k + tail;
        captured = '0;
        for (int k = 0; k <= r + 1; k++) begin
            ss_bar = (k < r) ? 1'b0 : 1'b1;
            mosi   = (k <= 9) ? frame[9-k] : 1'($urandom);
            if (read && !timeout && k == s) begin
                tx_valid = 1'b1;
                tx_data  = reply;
            end else if (read && k >= 10 && k < tx_end + (timeout ? 1 : 0)) begin
                tx_valid = 1'b0;
                tx_data  = 8'($urandom);
            end else begin
                tx_valid = 1'($urandom);
                tx_data  = 8'($urandom);
            end
            @(posedge clk);
            #1;
            e_rxd = (k >= 9 && r > 9) ? frame : last_rx;
            if (k < r) begin
                e_sready = 1'b0;
                e_rxv    = (k == 9);
                e_txr    = read && k >= 9 && k < tx_end;
                e_err    = timeout && (k == 9 + T);
                e_mv     = read && !timeout && k >= s && k <= s + 7;
                e_miso   = e_mv ? reply[7-(k-s)] : 1'b0;
            end else begin
                e_sready = (k > r) || (r >= end_k);
                e_err    = (k == r) && (r < end_k);
                e_rxv    = 1'b0;
                e_txr    = 1'b0;
                e_mv     = 1'b0;
                e_miso   = 1'b0;
            end
            if (miso_valid) captured = {captured[6:0], miso};
            chk_all(e_sready, e_rxv, e_rxd, e_txr, e_err, e_mv, e_miso);
        end
        if (r > 9) last_rx = frame;
    endtask

    initial begin
        rst_n    = 1'b0;
        ss_bar   = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #22;
        chk_all(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Write frame, then read with reply two cycles after tx_ready.
        run_frame(10'h1AA, 0, 8'h00, -1, 2);
        run_frame(10'h3C1, 1, 8'hA5, -1, 1);
        chk("captured_reply", 16'(captured), 16'h00A5);
        // Timeout, abort after five bits, then a clean frame.
        run_frame(10'h3C1, 100, 8'h00, -1, 3);
        run_frame(10'h155, 0, 8'h00, 5, 0);
        run_frame(10'h2F0, 0, 8'h00, -1, 0);
        run_frame(10'h3FF, 0, 8'h3C, -1, 0);
        chk("captured_fast", 16'(captured), 16'h003C);

        // Reset while the third reply bit is on MISO.
        for (int k = 0; k <= 12; k++) begin
            ss_bar   = 1'b0;
            mosi     = (k <= 9) ? last_rx[0] ^ 1'b1 : 1'b0;
            if (k <= 1) mosi = 1'b1;
            tx_valid = (k == 10);
            tx_data  = 8'hA5;
            @(posedge clk);
            #1;
        end
        chk("mv_before_reset", 16'(miso_valid), 16'h0001);
        chk("miso_bit3",       16'(miso),       16'h0001);
        rst_n = 1'b0;
        #1;
        chk_all(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        ss_bar   = 1'b1;
        tx_valid = 1'b0;
        #3;
        rst_n   = 1'b1;
        last_rx = '0;
        @(posedge clk);
        #1;
        chk_all(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [9:0] f;
            f = 10'($urandom);
            if ($urandom_range(0, 1) == 1) f[9:8] = 2'b11;
            run_frame(f, $urandom_range(0, 20), 8'($urandom),
                      ($urandom_range(0, 3) == 0) ? -2 : -1, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
